hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It computes the EX-stage operand forwarding selects and detects load-use hazards. It generates stall and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers on taken branches. It also runs a small FSM that holds an iterative multiply/divide instruction in EX for its full latency.

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RISC-V core.
//
// This block computes the EX operand forwarding selects. It detects load-use
// hazards and produces stall and flush controls for a taken branch. It also
// holds an iterative multiply or divide in EX for the full latency of the
// operation.
//
// Optional feature macro: HZD_MDU_EN
//   defined   - the MDU FSM and its latency counter are compiled in.
//   undefined - there is no MDU state. StallE, FlushM and the Mdu* outputs
//               are tied low, and MduStartE and MduDivE are ignored.
//
// Ports
//   clk, reset_n           core clock, asynchronous active-low reset
//   Rs1D, Rs2D             sources of the instruction in ID
//   Rs1E, Rs2E, RdE        sources and destination of the instruction in EX
//   RdM, RdW               destinations in MEM and WB
//   RegWriteM, RegWriteW   register-write enables in MEM and WB
//   LoadE                  EX instruction is a load
//   PCSrcE                 taken branch or jump resolved in EX
//   MduStartE, MduDivE     EX instruction is mul/div; 1 = divide
//   ForwardAE, ForwardBE   00 regfile, 10 MEM result, 01 WB result
//   StallF/D/E             hold the PC, IF/ID and ID/EX registers
//   FlushD/E/M             clear IF/ID, ID/EX and EX/MEM
//   MduLatch               MDU captures its forwarded operands this cycle
//   MduBusy                MDU FSM is not idle
//   MduDone                MDU result is valid in EX this cycle
//
// MDU FSM
//   state  | meaning
//   IDLE   | no operation; a start (without a branch) latches operands
//   BUSY   | counting down the latency; the pipeline is held
//   DONE   | result valid; the instruction advances, start is ignored
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       LoadE,
    input  logic       PCSrcE,
    input  logic       MduStartE,
    input  logic       MduDivE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MduLatch,
    output logic       MduBusy,
    output logic       MduDone
);

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       lw_stall;
    logic       mdu_stall;
    logic       mdu_latch;
    logic       mdu_busy;
    logic       mdu_done;

    // MEM has priority over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m == rs) && (rs != 5'd0)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w == rs) && (rs != 5'd0)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign fwd_a    = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign fwd_b    = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef HZD_MDU_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    mdu_state_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        mdu_latch = 1'b0;
        mdu_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A simultaneous branch kills the MDU instruction, so it never starts.
                if (MduStartE && !PCSrcE) begin
                    mdu_latch = 1'b1;
                    mdu_stall = 1'b1;
                    cnt_d     = MduDivE ? DIV_CNT : MUL_CNT;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                mdu_stall = 1'b1;
                if (cnt_q == 6'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DONE: begin
                mdu_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mdu_busy = (state_q != S_IDLE);
`else
    assign mdu_stall = 1'b0;
    assign mdu_latch = 1'b0;
    assign mdu_busy  = 1'b0;
    assign mdu_done  = 1'b0;

    logic unused_mdu;
    assign unused_mdu = &{1'b0, clk, MduStartE, MduDivE, MUL_CNT, DIV_CNT};
`endif

    // Every output reads as zero while reset is held, including the forwarding selects.
    // An MDU stall freezes EX, so flushes that would kill the MDU instruction are masked.
    assign ForwardAE = reset_n ? fwd_a : 2'b00;
    assign ForwardBE = reset_n ? fwd_b : 2'b00;
    assign StallF    = reset_n & (mdu_stall | (lw_stall & ~PCSrcE));
    assign StallD    = reset_n & (mdu_stall | (lw_stall & ~PCSrcE));
    assign StallE    = reset_n & mdu_stall;
    assign FlushD    = reset_n & PCSrcE & ~mdu_stall;
    assign FlushE    = reset_n & (lw_stall | PCSrcE) & ~mdu_stall;
    assign FlushM    = reset_n & mdu_stall;
    assign MduLatch  = reset_n & mdu_latch;
    assign MduBusy   = reset_n & mdu_busy;
    assign MduDone   = reset_n & mdu_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LAT=4, DIV_LAT=32).
// The control outputs are packed as {StallF,StallD,StallE,FlushD,FlushE,FlushM,MduLatch,MduBusy,MduDone}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MduStartE, MduDivE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic       MduLatch, MduBusy, MduDone;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MduStartE(MduStartE), .MduDivE(MduDivE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MduLatch(MduLatch), .MduBusy(MduBusy), .MduDone(MduDone)
    );

    logic [8:0] ctrl;
    assign ctrl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MduLatch, MduBusy, MduDone};

    localparam logic [8:0] C_NONE  = 9'b000_000_000;
    localparam logic [8:0] C_LW    = 9'b110_010_000;
    localparam logic [8:0] C_BR    = 9'b000_110_000;
    localparam logic [8:0] C_START = 9'b111_001_100;
    localparam logic [8:0] C_BUSY  = 9'b111_001_010;
    localparam logic [8:0] C_DONE  = 9'b000_000_011;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        LoadE = 1'b0; PCSrcE = 1'b0; MduStartE = 1'b0; MduDivE = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        idle_inputs();
        reset_n = 1'b0;
        RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
        LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
        #2;
        chk("rst_fwdA", 16'(ForwardAE), 16'h0);
        chk("rst_fwdB", 16'(ForwardBE), 16'h0);
        chk("rst_ctrl", 16'(ctrl), 16'(C_NONE));
        step();
        reset_n = 1'b1;
        idle_inputs();
        step();

        // Forwarding
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; #1;
        chk("fwdA_mem", 16'(ForwardAE), 16'h2);
        RegWriteM = 1'b0; #1;
        chk("fwdA_wb", 16'(ForwardAE), 16'h1);
        Rs1E = 5'd0; #1;
        chk("fwdA_x0", 16'(ForwardAE), 16'h0);
        RegWriteM = 1'b1; RdM = 5'd9; Rs2E = 5'd9; RdW = 5'd9; #1;
        chk("fwdB_mem", 16'(ForwardBE), 16'h2);
        RdM = 5'd3; #1;
        chk("fwdB_wb", 16'(ForwardBE), 16'h1);
        RegWriteW = 1'b0; #1;
        chk("fwdB_none", 16'(ForwardBE), 16'h0);
        idle_inputs(); step();

        // Load-use
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; #1;
        chk("lw_rs2", 16'(ctrl), 16'(C_LW));
        step();
        LoadE = 1'b0; #1;
        chk("lw_one_cycle", 16'(ctrl), 16'(C_NONE));
        LoadE = 1'b1; RdE = 5'd0; Rs2D = 5'd0; #1;
        chk("lw_rd0", 16'(ctrl), 16'(C_NONE));
        RdE = 5'd12; Rs1D = 5'd12; #1;
        chk("lw_rs1", 16'(ctrl), 16'(C_LW));
        Rs1D = 5'd13; #1;
        chk("lw_nomatch", 16'(ctrl), 16'(C_NONE));

        // Branch overrides load-use
        Rs1D = 5'd12; PCSrcE = 1'b1; #1;
        chk("br_over_lw", 16'(ctrl), 16'(C_BR));
        LoadE = 1'b0; #1;
        chk("br_only", 16'(ctrl), 16'(C_BR));
        idle_inputs(); step();

        // Multiply, MUL_LAT=4
        MduStartE = 1'b1; MduDivE = 1'b0; #1;
`ifdef HZD_MDU_EN
        chk("mul_c1", 16'(ctrl), 16'(C_START));
        for (int c = 2; c <= 5; c++) begin
            step();
            if (c == 3) begin
                PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4; #1;
            end
            chk($sformatf("mul_c%0d", c), 16'(ctrl), 16'(C_BUSY));
            if (c == 3) begin
                PCSrcE = 1'b0; LoadE = 1'b0;
            end
        end
        step();
        chk("mul_c6", 16'(ctrl), 16'(C_DONE));
        MduStartE = 1'b0;
        step();
        chk("mul_c7", 16'(ctrl), 16'(C_NONE));
`else
        chk("nomdu_start", 16'(ctrl), 16'(C_NONE));
        step();
        PCSrcE = 1'b1; #1;
        chk("nomdu_br", 16'(ctrl), 16'(C_BR));
        PCSrcE = 1'b0; MduStartE = 1'b0;
        step();
`endif
        idle_inputs(); step();

        // Divide aborted by reset at BUSY cycle 10
        MduStartE = 1'b1; MduDivE = 1'b1;
        for (int c = 0; c < 10; c++) step();
        RdM = 5'd6; RegWriteM = 1'b1; Rs1E = 5'd6;
        reset_n = 1'b0; #1;
        chk("abort_ctrl", 16'(ctrl), 16'(C_NONE));
        chk("abort_fwdA", 16'(ForwardAE), 16'h0);
        step();
        MduStartE = 1'b0; reset_n = 1'b1; #1;
        chk("abort_busy", 16'(MduBusy), 16'h0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            seen = seen | MduDone | MduBusy;
            step();
        end
        chk("abort_no_done", 16'(seen), 16'h0);
        idle_inputs(); step();

        // Back-to-back divides
        MduStartE = 1'b1; MduDivE = 1'b1; #1;
`ifdef HZD_MDU_EN
        chk("b2b_latch1", 16'(MduLatch), 16'h1);
        n = 0;
        while (!MduDone && n < 100) begin step(); n++; end
        chk("b2b_lat1", 16'(n), 16'd33);
        step();
        chk("b2b_latch2", 16'(ctrl), 16'(C_START));
        n = 0;
        while (!MduDone && n < 100) begin step(); n++; end
        chk("b2b_lat2", 16'(n), 16'd33);
        MduStartE = 1'b0;
        step();
        chk("b2b_end", 16'(ctrl), 16'(C_NONE));
`else
        seen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            seen = seen | StallE;
            step();
        end
        chk("nomdu_stallE", 16'(seen), 16'h0);
        MduStartE = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
